// File: rtl/fdtd_ctrl_pkg.sv
// Shared types for the FDTD sweep controller: FSM states, field phases and
// the per-cell tracking entry that follows a read through the datapath.
package fdtd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_E_SWEEP,
      ST_E_DRAIN,
      ST_H_SWEEP,
      ST_H_DRAIN,
      ST_DONE
   } state_t;

   localparam logic PHASE_E = 1'b0;
   localparam logic PHASE_H = 1'b1;

   // Address field is sized for the widest grid; users keep the low bits.
   localparam int PIPE_ADDR_W = 32;

   typedef struct packed {
      logic                   valid;
      logic [PIPE_ADDR_W-1:0] addr;
      logic                   phase;
   } pipe_entry_t;

endpackage

// File: rtl/fdtd_valid_pipe.sv
// PIPE_LAT-deep shift register of tracking entries with a hold enable.
// Reports the tail and whether nothing will remain in flight after this cycle.
module fdtd_valid_pipe
   import fdtd_ctrl_pkg::*;
#(
   parameter int PIPE_LAT = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        hold,
   input  pipe_entry_t entry_in,
   output pipe_entry_t tail,
   output logic        empty_after_shift
);

   pipe_entry_t         entry_reg [PIPE_LAT];
   logic [PIPE_LAT-1:0] valid_vec;
   logic                head_busy;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            entry_reg[i] <= '0;
         end
      end else if (!hold) begin
         entry_reg[0] <= entry_in;
         for (int i = 1; i < PIPE_LAT; i++) begin
            entry_reg[i] <= entry_reg[i-1];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_LAT; gi++) begin : g_valid
         assign valid_vec[gi] = entry_reg[gi].valid;
      end
      if (PIPE_LAT > 1) begin : g_multi
         assign head_busy = |valid_vec[PIPE_LAT-2:0];
      end else begin : g_single
         assign head_busy = 1'b0;
      end
   endgenerate

   assign tail = entry_reg[PIPE_LAT-1];

   // The tail drains this cycle only if it is written, i.e. not held.
   assign empty_after_shift = !head_busy && (!valid_vec[PIPE_LAT-1] || !hold);

endmodule

// File: rtl/fdtd_sweep_ctrl.sv
// FDTD time-step sequencer: alternating E and H raster sweeps over the grid,
// with write-back addresses tracked through a fixed-latency datapath.
module fdtd_sweep_ctrl
   import fdtd_ctrl_pkg::*;
#(
   parameter int NX         = 16,
   parameter int NY         = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int PIPE_LAT   = 2,
   parameter int ITER_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start_i,
   input  logic [ITER_WIDTH-1:0] num_iter_i,
   input  logic                  stall_i,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  phase_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  wr_phase_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ITER_WIDTH-1:0] iter_cnt_o
);

   localparam int                    N_CELLS   = NX * NY;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_CELLS - 1);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   issue_cnt_reg, issue_cnt_next;
   logic [ITER_WIDTH-1:0]   iter_cnt_reg, iter_cnt_next;
   logic [ITER_WIDTH-1:0]   num_iter_reg, num_iter_next;
   logic [ITER_WIDTH-1:0]   iter_inc;
   pipe_entry_t             pipe_in;
   pipe_entry_t             pipe_tail;
   logic                    pipe_empty_next;

   assign iter_inc = iter_cnt_reg + ITER_WIDTH'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= ST_IDLE;
         issue_cnt_reg <= '0;
         iter_cnt_reg  <= '0;
         num_iter_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         issue_cnt_reg <= issue_cnt_next;
         iter_cnt_reg  <= iter_cnt_next;
         num_iter_reg  <= num_iter_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      issue_cnt_next = issue_cnt_reg;
      iter_cnt_next  = iter_cnt_reg;
      num_iter_next  = num_iter_reg;
      rd_en_o        = 1'b0;
      rd_addr_o      = '0;
      phase_o        = PHASE_E;
      busy_o         = 1'b0;
      done_o         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               if (num_iter_i != '0) begin
                  state_next    = ST_E_SWEEP;
                  num_iter_next = num_iter_i;
                  iter_cnt_next = '0;
               end else begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_E_SWEEP, ST_H_SWEEP: begin
            busy_o    = 1'b1;
            rd_en_o   = !stall_i;
            rd_addr_o = issue_cnt_reg;
            phase_o   = (state_reg == ST_H_SWEEP) ? PHASE_H : PHASE_E;
            if (rd_en_o) begin
               if (issue_cnt_reg == LAST_ADDR) begin
                  issue_cnt_next = '0;
                  state_next     = (state_reg == ST_H_SWEEP) ? ST_H_DRAIN : ST_E_DRAIN;
               end else begin
                  issue_cnt_next = issue_cnt_reg + ADDR_WIDTH'(1);
               end
            end
         end
         ST_E_DRAIN: begin
            busy_o = 1'b1;
            if (pipe_empty_next) begin
               state_next = ST_H_SWEEP;
            end
         end
         ST_H_DRAIN: begin
            busy_o = 1'b1;
            if (pipe_empty_next) begin
               iter_cnt_next = iter_inc;
               state_next    = (iter_inc == num_iter_reg) ? ST_DONE : ST_E_SWEEP;
            end
         end
         ST_DONE: begin
            done_o     = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      pipe_in       = '0;
      pipe_in.valid = rd_en_o;
      pipe_in.addr  = PIPE_ADDR_W'(rd_addr_o);
      pipe_in.phase = phase_o;
   end

   fdtd_valid_pipe #(
      .PIPE_LAT (PIPE_LAT)
   ) u_valid_pipe (
      .CLK               (CLK),
      .RST               (RST),
      .hold              (stall_i),
      .entry_in          (pipe_in),
      .tail              (pipe_tail),
      .empty_after_shift (pipe_empty_next)
   );

   assign wr_en_o    = pipe_tail.valid & !stall_i;
   assign wr_addr_o  = pipe_tail.addr[ADDR_WIDTH-1:0];
   assign wr_phase_o = pipe_tail.phase;
   assign iter_cnt_o = iter_cnt_reg;

   genvar gi;
   generate
      if (ADDR_WIDTH < PIPE_ADDR_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = |pipe_tail.addr[PIPE_ADDR_W-1:ADDR_WIDTH];
      end
   endgenerate

endmodule
